clear_redraw: RTL and testbench

- Line-clear and piece-spawn datapath for the Tetris game core.
- Holds an 8-row x 4-column playfield register, packed into 32 bits.
- On command from the top-level FSM (state code), it loads a board, removes full rows, or spawns the current piece at the top.
- Signals game-over through a sticky error flag when a spawned piece collides with occupied cells.

---
 rtl/clear_redraw_if.sv | 33 +++
 rtl/clear_redraw.sv | 105 ++++++++++
 tb/tb_clear_redraw.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/clear_redraw_if.sv
// clear_redraw_if
//   Command/board bus between the top-level game FSM and the clear_redraw
//   datapath.
//   state      : 3-bit command code (4 LOAD, 1 CLEAR, 2 SPAWN, others hold)
//   board_in   : 32-bit board presented for LOAD
//   curr_piece : 2-bit piece type presented for SPAWN
//   board_out  : registered playfield (row r = bits [4r+3:4r], row 0 bottom)
//   error      : registered sticky game-over flag
interface clear_redraw_if;
  logic [2:0]  state;
  logic [31:0] board_in;
  logic [1:0]  curr_piece;
  logic [31:0] board_out;
  logic        error;

  // Game FSM side: issues commands, observes the board.
  modport master (
    output state,
    output board_in,
    output curr_piece,
    input  board_out,
    input  error
  );

  // Datapath side.
  modport slave (
    input  state,
    input  board_in,
    input  curr_piece,
    output board_out,
    output error
  );
endinterface

// File: rtl/clear_redraw.sv
// clear_redraw
//   Line-clear and piece-spawn datapath for the Tetris core. Holds an
//   8-row x 4-column playfield packed into 32 bits and applies one command
//   per clka cycle with single-cycle latency.
// Ports:
//   clka    : system clock, all state updates on its rising edge
//   clkb    : kept only for harness port compatibility, not used
//   restart : synchronous active-high reset (board and error cleared)
//   bus     : clear_redraw_if.slave (state, board_in, curr_piece in;
//             board_out, error out)
module clear_redraw (
  input  logic           clka,
  input  logic           clkb,
  input  logic           restart,
  clear_redraw_if.slave  bus
);

  localparam logic [2:0] CMD_CLEAR = 3'd1;
  localparam logic [2:0] CMD_SPAWN = 3'd2;
  localparam logic [2:0] CMD_LOAD  = 3'd4;

  localparam int ROWS = 8;

  logic [31:0] board_q;
  logic        error_q;

  logic [31:0] cleared;
  logic [31:0] spawn_mask;
  logic        collide;
  logic [31:0] board_d;
  logic        error_d;

  // clkb deliberately drives nothing.
  logic unused_clkb;
  assign unused_clkb = clkb;

  // Row compaction: walk rows bottom-up and copy every non-full row into
  // the next free slot from row 0. Slots never written remain zero, which
  // gives the empty rows that drop in at the top.
  always_comb begin
    logic [2:0] slot;
    cleared = '0;
    slot    = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (board_q[4*r +: 4] != 4'hF) begin
        cleared[{slot, 2'b00} +: 4] = board_q[4*r +: 4];
        slot = slot + 3'd1;
      end
    end
  end

  // Spawn shapes occupy rows 7 and 6 only.
  always_comb begin
    spawn_mask = '0;
    case (bus.curr_piece)
      2'd0:    spawn_mask = 32'h6600_0000;  // O
      2'd1:    spawn_mask = 32'hF000_0000;  // I
      2'd2:    spawn_mask = 32'h6300_0000;  // S
      default: spawn_mask = 32'h7200_0000;  // T
    endcase
  end

  assign collide = |(board_q & spawn_mask);

  // Once error is set, only LOAD (or restart) may change the board.
  always_comb begin
    board_d = board_q;
    error_d = error_q;
    case (bus.state)
      CMD_LOAD: begin
        board_d = bus.board_in;
      end
      CMD_CLEAR: begin
        if (!error_q) begin
          board_d = cleared;
        end
      end
      CMD_SPAWN: begin
        if (!error_q) begin
          if (collide) begin
            error_d = 1'b1;
          end else begin
            board_d = board_q | spawn_mask;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clka) begin
    if (restart) begin
      board_q <= '0;
      error_q <= 1'b0;
    end else begin
      board_q <= board_d;
      error_q <= error_d;
    end
  end

  assign bus.board_out = board_q;
  assign bus.error     = error_q;

endmodule

// File: tb/tb_clear_redraw.sv
// tb_clear_redraw
//   Self-checking bench for clear_redraw: directed scenarios followed by
//   randomized commands, compared against a row-list reference model.
module tb_clear_redraw;

  logic clka = 1'b0;
  logic clkb = 1'b0;
  logic restart;

  clear_redraw_if bus ();

  clear_redraw dut (
    .clka    (clka),
    .clkb    (clkb),
    .restart (restart),
    .bus     (bus)
  );

  always #5 clka = ~clka;
  always #7 clkb = ~clkb;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] model_board;
  logic        model_err;
  logic [31:0] piece_masks [4] = '{32'h66000000, 32'hF0000000,
                                   32'h63000000, 32'h72000000};

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_clear(input logic [31:0] b);
    logic [3:0]  kept [$];
    logic [31:0] res;
    res = '0;
    for (int r = 0; r < 8; r++)
      if (b[4*r +: 4] != 4'hF) kept.push_back(b[4*r +: 4]);
    for (int i = 0; i < kept.size(); i++)
      res[4*i +: 4] = kept[i];
    return res;
  endfunction

  task automatic model_update(input logic rst, input logic [2:0] st,
                              input logic [31:0] bin, input logic [1:0] pc);
    logic [31:0] m;
    if (rst) begin
      model_board = '0;
      model_err   = 1'b0;
    end else if (st == 3'd4) begin
      model_board = bin;
    end else if (st == 3'd1 && !model_err) begin
      model_board = model_clear(model_board);
    end else if (st == 3'd2 && !model_err) begin
      m = piece_masks[pc];
      if ((model_board & m) == 0) model_board = model_board | m;
      else model_err = 1'b1;
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic [2:0] st,
                      input logic [31:0] bin, input logic [1:0] pc);
    restart        = rst;
    bus.state      = st;
    bus.board_in   = bin;
    bus.curr_piece = pc;
    @(posedge clka);
    model_update(rst, st, bin, pc);
    #1;
    check({tag, ".board"}, bus.board_out, model_board);
    check({tag, ".error"}, {31'd0, bus.error}, {31'd0, model_err});
  endtask

  // Directed step that also checks against a literal expected value.
  task automatic step_exp(input string tag, input logic rst, input logic [2:0] st,
                          input logic [31:0] bin, input logic [1:0] pc,
                          input logic [31:0] exp_board, input logic exp_err);
    step(tag, rst, st, bin, pc);
    check({tag, ".lit_board"}, bus.board_out, exp_board);
    check({tag, ".lit_error"}, {31'd0, bus.error}, {31'd0, exp_err});
  endtask

  function automatic logic [31:0] rand_board();
    logic [31:0] b;
    for (int r = 0; r < 8; r++)
      b[4*r +: 4] = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
    return b;
  endfunction

  initial begin
    logic [31:0] clr_in  [4] = '{32'h00000F12, 32'h0000FF03, 32'hF1F2F3F4, 32'hFFFFFFFF};
    logic [31:0] clr_out [4] = '{32'h00000012, 32'h00000003, 32'h00001234, 32'h00000000};
    logic [2:0]  st;
    logic        rst;
    model_board    = '0;
    model_err      = 1'b0;
    restart        = 1'b1;
    bus.state      = 3'd0;
    bus.board_in   = '0;
    bus.curr_piece = '0;

    step_exp("reset", 1'b1, 3'd4, 32'hDEADBEEF, 2'd2, 32'h0, 1'b0);

    step_exp("load", 1'b0, 3'd4, 32'h20000000, 2'd0, 32'h20000000, 1'b0);
    step_exp("clear_none", 1'b0, 3'd1, 32'h0, 2'd0, 32'h20000000, 1'b0);
    for (int i = 0; i < 4; i++)
      step_exp("hold", 1'b0, 3'd0, 32'hFFFFFFFF, 2'd1, 32'h20000000, 1'b0);
    step_exp("reset_mid", 1'b1, 3'd0, 32'h0, 2'd0, 32'h0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      step("clr_load", 1'b0, 3'd4, clr_in[i], 2'd0);
      step_exp("clear", 1'b0, 3'd1, 32'h0, 2'd0, clr_out[i], 1'b0);
    end

    step_exp("spawn_o_ld", 1'b0, 3'd4, 32'h0, 2'd0, 32'h0, 1'b0);
    step_exp("spawn_o", 1'b0, 3'd2, 32'h0, 2'd0, 32'h66000000, 1'b0);
    step("spawn_t_ld", 1'b0, 3'd4, 32'h00000001, 2'd0);
    step_exp("spawn_t", 1'b0, 3'd2, 32'h0, 2'd3, 32'h72000001, 1'b0);

    step("coll_ld", 1'b0, 3'd4, 32'h20000000, 2'd0);
    step_exp("collide", 1'b0, 3'd2, 32'h0, 2'd1, 32'h20000000, 1'b1);
    step_exp("err_clear", 1'b0, 3'd1, 32'h0, 2'd0, 32'h20000000, 1'b1);
    step_exp("err_spawn", 1'b0, 3'd2, 32'h0, 2'd2, 32'h20000000, 1'b1);
    step_exp("err_load", 1'b0, 3'd4, 32'h0000FFFF, 2'd0, 32'h0000FFFF, 1'b1);
    step_exp("err_clear2", 1'b0, 3'd1, 32'h0, 2'd0, 32'h0000FFFF, 1'b1);
    step_exp("err_reset", 1'b1, 3'd2, 32'h0, 2'd0, 32'h0, 1'b0);

    step_exp("rst_vs_load", 1'b1, 3'd4, 32'hFFFF0000, 2'd0, 32'h0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      case ($urandom_range(0, 9))
        0, 1, 2: st = 3'd4;
        3, 4, 5: st = 3'd1;
        6, 7:    st = 3'd2;
        default: st = 3'($urandom_range(0, 7));
      endcase
      step("rand", rst, st,
           ($urandom_range(0, 2) == 0) ? 32'($urandom) : rand_board(),
           2'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
